// File: rtl/conv_mac_engine.sv
// Streaming signed dot-product engine: LANES multiplies per beat, bias add and OUT_W saturation.
// Optional macro CONV_MAC_RELU_EN clamps negative results to zero.
module conv_mac_engine #(
    parameter int DATA_W = 22,
    parameter int WGT_W  = 9,
    parameter int BIAS_W = 9,
    parameter int LANES  = 8,
    parameter int N_TAPS = 800,
    parameter int ACC_W  = 42,
    parameter int OUT_W  = 30
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BIAS_W-1:0]         bias,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic [LANES*WGT_W-1:0]    in_wgt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic                      busy,
    output logic                      sat_flag
);

    localparam int BEATS      = (N_TAPS + LANES - 1) / LANES;
    localparam int LAST_LANES = N_TAPS - (BEATS - 1) * LANES;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PROD_W     = DATA_W + WGT_W;

    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, ACCUM, FINISH, DONE} state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [CNT_W-1:0]         r_beat_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic [BIAS_W-1:0]        r_bias;
    logic [OUT_W-1:0]         r_out_data;
    logic                     r_sat;

    logic                     w_beat_acc;
    logic                     w_last_beat;
    logic signed [ACC_W-1:0]  w_lane_term [LANES];
    logic signed [ACC_W-1:0]  w_beat_sum;
    logic signed [ACC_W:0]    w_total;
    logic [OUT_W-1:0]         w_res_data;
    logic                     w_res_sat;

    assign w_beat_acc  = in_valid && in_ready;
    assign w_last_beat = (r_beat_cnt == CNT_W'(BEATS - 1));

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [DATA_W-1:0] w_d;
            logic signed [WGT_W-1:0]  w_w;
            logic signed [PROD_W-1:0] w_p;
            logic signed [ACC_W-1:0]  w_p_ext;
            assign w_d     = in_data[gi*DATA_W +: DATA_W];
            assign w_w     = in_wgt[gi*WGT_W +: WGT_W];
            assign w_p     = w_d * w_w;
            assign w_p_ext = {{(ACC_W-PROD_W){w_p[PROD_W-1]}}, w_p};
            // Lanes past the tap count carry don't-care data on the final beat.
            if (gi >= LAST_LANES) begin : g_tail
                assign w_lane_term[gi] = w_last_beat ? '0 : w_p_ext;
            end else begin : g_full
                assign w_lane_term[gi] = w_p_ext;
            end
        end
    endgenerate

    always_comb begin
        w_beat_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            w_beat_sum = w_beat_sum + w_lane_term[k];
        end
    end

    assign w_total = {r_acc[ACC_W-1], r_acc} + {{(ACC_W+1-BIAS_W){r_bias[BIAS_W-1]}}, r_bias};

    always_comb begin
        w_res_data = w_total[OUT_W-1:0];
        w_res_sat  = 1'b0;
        if (w_total > SAT_MAX) begin
            w_res_data = SAT_MAX[OUT_W-1:0];
            w_res_sat  = 1'b1;
        end else if (w_total < SAT_MIN) begin
            w_res_data = SAT_MIN[OUT_W-1:0];
            w_res_sat  = 1'b1;
        end
`ifdef CONV_MAC_RELU_EN
        if (w_res_data[OUT_W-1]) begin
            w_res_data = '0;
            w_res_sat  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = ACCUM;
            ACCUM:   if (w_beat_acc && w_last_beat) w_state_next = FINISH;
            FINISH:  w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ACCUM);
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_bias     <= '0;
            r_out_data <= '0;
            r_sat      <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_acc      <= '0;
                r_beat_cnt <= '0;
                r_bias     <= bias;
            end
            if (w_beat_acc) begin
                r_acc      <= r_acc + w_beat_sum;
                r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
            end
            if (r_state == FINISH) begin
                r_out_data <= w_res_data;
                r_sat      <= w_res_sat;
            end
        end
    end

    assign out_data = r_out_data;
    assign sat_flag = r_sat;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed table-driven bench for conv_mac_engine (default build plus a small 4-lane/10-tap instance).
module tb_conv_mac_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, in_valid, out_ready;
    logic [8:0]   bias;
    logic [175:0] in_data;
    logic [71:0]  in_wgt;
    logic         in_ready, out_valid, busy, sat_flag;
    logic [29:0]  out_data;

    logic         s_start, s_in_valid, s_out_ready;
    logic [8:0]   s_bias;
    logic [87:0]  s_in_data;
    logic [35:0]  s_in_wgt;
    logic         s_in_ready, s_out_valid, s_busy, s_sat_flag;
    logic [29:0]  s_out_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    conv_mac_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_wgt(in_wgt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .sat_flag(sat_flag)
    );

    conv_mac_engine #(.LANES(4), .N_TAPS(10)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .bias(s_bias),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_wgt(s_in_wgt),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .busy(s_busy), .sat_flag(s_sat_flag)
    );

    typedef struct {
        logic signed [21:0] d;
        logic signed [8:0]  w;
        logic signed [8:0]  b;
        logic signed [63:0] exp_data;
        logic               exp_sat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic signed [21:0] d, input logic signed [8:0] w,
                          input logic signed [8:0] b, input bit gaps,
                          input logic signed [63:0] exp_d, input logic exp_s);
        int waited;
        logic [29:0] held;
        start   = 1'b1;
        bias    = b;
        in_data = {8{d}};
        in_wgt  = {8{w}};
        @(posedge clk); #1;
        start = 1'b0;
        bias  = 9'h0AA;
        chk({tag, " busy"}, busy, 1);
        for (int i = 0; i < 100; i++) begin
            if (gaps) begin
                if (i == 40) begin
                    in_valid = 1'b0;
                    start    = 1'b1;
                    @(posedge clk); #1;
                    start = 1'b0;
                end
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk({tag, " finish_valid_lo"}, out_valid, 0);
        @(posedge clk); #1;
        chk({tag, " valid_2nd_edge"}, out_valid, 1);
        waited = 0;
        while (!out_valid && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk({tag, " data"}, $signed(out_data), exp_d);
        chk({tag, " sat"}, sat_flag, exp_s);
        if (gaps) begin
            held = out_data;
            for (int c = 0; c < 10; c++) begin
                start = (c == 4);
                @(posedge clk); #1;
                start = 1'b0;
                chk({tag, " hold_valid"}, out_valid, 1);
                chk({tag, " hold_data"}, out_data, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " released"}, out_valid, 0);
        chk({tag, " idle"}, busy, 0);
        $display("op %s: out_data=%0d sat=%0d", tag, $signed(out_data), sat_flag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{d: 22'sd1,        w: 9'sd1,   b: 9'sd5,    exp_data: 805,        exp_sat: 1'b0};
        vecs[2] = '{d: 22'sd2097151,  w: 9'sd255, b: 9'sd255,  exp_data: 536870911,  exp_sat: 1'b1};
`ifdef CONV_MAC_RELU_EN
        vecs[1] = '{d: -22'sd3,       w: 9'sd2,   b: -9'sd4,   exp_data: 0,          exp_sat: 1'b0};
        vecs[3] = '{d: -22'sd2097152, w: 9'sd255, b: 9'sd0,    exp_data: 0,          exp_sat: 1'b0};
        vecs[4] = '{d: 22'sd0,        w: 9'sd77,  b: -9'sd256, exp_data: 0,          exp_sat: 1'b0};
        vecs[5] = '{d: 22'sd1000,     w: -9'sd7,  b: 9'sd100,  exp_data: 0,          exp_sat: 1'b0};
`else
        vecs[1] = '{d: -22'sd3,       w: 9'sd2,   b: -9'sd4,   exp_data: -4804,      exp_sat: 1'b0};
        vecs[3] = '{d: -22'sd2097152, w: 9'sd255, b: 9'sd0,    exp_data: -536870912, exp_sat: 1'b1};
        vecs[4] = '{d: 22'sd0,        w: 9'sd77,  b: -9'sd256, exp_data: -256,       exp_sat: 1'b0};
        vecs[5] = '{d: 22'sd1000,     w: -9'sd7,  b: 9'sd100,  exp_data: -5599900,   exp_sat: 1'b0};
`endif
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        bias = '0; in_data = '0; in_wgt = '0;
        s_start = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
        s_bias = '0; s_in_data = '0; s_in_wgt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset sat", sat_flag, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) begin
            run_op($sformatf("vec%0d", v), vecs[v].d, vecs[v].w, vecs[v].b, 1'b0,
                   vecs[v].exp_data, vecs[v].exp_sat);
        end

        run_op("gaps_hold", 22'sd7, 9'sd3, 9'sd11, 1'b1, 16811, 1'b0);

        // Abandon an operation mid-stream with an asynchronous reset.
        start = 1'b1; bias = 9'sd9; in_data = {8{22'sd5}}; in_wgt = {8{9'sd5}};
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst busy", busy, 0);
        chk("async_rst in_ready", in_ready, 0);
        chk("async_rst out_data", out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("after_rst out_valid", out_valid, 0);
        chk("after_rst sat", sat_flag, 0);
        @(posedge clk); #1;
        run_op("post_reset", 22'sd1, 9'sd1, 9'sd0, 1'b0, 800, 1'b0);

        // Partial final beat: lanes 2-3 of beat 3 carry junk and must not count.
        s_start = 1'b1; s_bias = 9'sd0;
        @(posedge clk); #1;
        s_start = 1'b0;
        s_in_wgt = {4{9'sd1}};
        s_in_data = {4{22'sd1}};
        s_in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("small in_ready beat3", s_in_ready, 1);
        s_in_data = {22'sd1000, -22'sd777, 22'sd1, 22'sd1};
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        chk("small finish in_ready", s_in_ready, 0);
        chk("small finish valid_lo", s_out_valid, 0);
        @(posedge clk); #1;
        chk("small valid", s_out_valid, 1);
        chk("small data", $signed(s_out_data), 10);
        chk("small sat", s_sat_flag, 0);
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        chk("small idle", s_busy, 0);
        $display("op small: out_data=%0d sat=%0d", $signed(s_out_data), s_sat_flag);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv_mac_engine.md
CONV_MAC_ENGINE -- requirements
Module: conv_mac_engine

Interface
REQ-001 Parameter DATA_W, default 22: signed activation width per lane.
REQ-002 Parameter WGT_W, default 9: signed weight width per lane.
REQ-003 Parameter BIAS_W, default 9: signed bias width.
REQ-004 Parameter LANES, default 8: multiplies per accepted beat.
REQ-005 Parameter N_TAPS, default 800: products per dot product.
REQ-006 Parameter ACC_W, default 42: accumulator width, >= DATA_W+WGT_W+ceil(log2(N_TAPS)).
REQ-007 Parameter OUT_W, default 30: signed result width.
REQ-008 clk  in  1  sole clock; all state updates on the rising edge.
REQ-009 rst_n  in  1  asynchronous, active-low reset.
REQ-010 start  in  1  one-cycle request to begin a dot product.
REQ-011 bias  in  BIAS_W  signed bias, sampled on accepted start.
REQ-012 in_valid  in  1  beat valid.
REQ-013 in_ready  out  1  engine accepts a beat.
REQ-014 in_data  in  LANES*DATA_W  activations; lane k at bits [k*DATA_W +: DATA_W], lane 0 at LSB.
REQ-015 in_wgt  in  LANES*WGT_W  weights; same lane packing as in_data.
REQ-016 out_valid  out  1  result valid.
REQ-017 out_ready  in  1  consumer accepts the result.
REQ-018 out_data  out  OUT_W  signed result.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 sat_flag  out  1  result was clipped; valid while out_valid is high.

Function
REQ-021 The FSM SHALL have states IDLE, ACCUM, FINISH and DONE.
REQ-022 IDLE: start=1 SHALL clear the accumulator and beat counter, capture bias, and move to ACCUM; all other inputs are ignored.
REQ-023 ACCUM: in_ready SHALL be 1; a beat is accepted when in_valid and in_ready are both 1 on a clock edge.
REQ-024 Each accepted beat SHALL add the sum of LANES signed products, each sign-extended to ACC_W, into the accumulator.
REQ-025 Beats per operation SHALL be ceil(N_TAPS/LANES); in the final beat, lanes with index >= N_TAPS - (beats-1)*LANES SHALL contribute zero.
REQ-026 Acceptance of the final beat SHALL move the FSM to FINISH; in_valid low holds ACCUM with the accumulator unchanged.
REQ-027 FINISH (one cycle): the FSM SHALL add the sign-extended bias, saturate to the OUT_W signed range, register out_data and sat_flag, then move to DONE.
REQ-028 out_valid SHALL rise exactly 2 clock edges after the edge that accepted the final beat.
REQ-029 DONE: out_valid=1; out_data and sat_flag SHALL hold stable until out_valid and out_ready are both 1, and the FSM then returns to IDLE.
REQ-030 start SHALL be ignored while busy=1; in_ready SHALL be 0 in IDLE, FINISH and DONE.
REQ-031 Saturation: a sum above 2^(OUT_W-1)-1 SHALL clip to that value, a sum below -2^(OUT_W-1) SHALL clip to that value, and in both cases sat_flag=1; otherwise sat_flag=0.

Reset
REQ-032 When rst_n=0, regardless of clk, the FSM SHALL go to IDLE; the accumulator, beat counter, captured bias, out_data and sat_flag SHALL be 0; out_valid, in_ready and busy SHALL be 0.
REQ-033 Reset during ACCUM, FINISH or DONE SHALL abandon the operation with no partial result; the next start SHALL produce a fully correct result.

Configuration
REQ-034 Macro CONV_MAC_RELU_EN defined: FINISH SHALL replace a negative saturated result with 0 and clear sat_flag if the clip was negative.
REQ-035 Macro CONV_MAC_RELU_EN undefined: the signed saturated result SHALL be output unchanged.

Verification (defaults, macro undefined unless stated)
REQ-036 100 beats, all data=1, all wgt=1, bias=5 -> out_data=805, sat_flag=0, out_valid 2 edges after beat 100.
REQ-037 Data=-3, wgt=2 in all lanes, bias=-4 -> out_data=-4804; with CONV_MAC_RELU_EN defined -> out_data=0.
REQ-038 Data=2097151, wgt=255 in all lanes, bias=255 -> out_data=536870911, sat_flag=1.
REQ-039 Random in_valid gaps plus out_ready held low 10 cycles in DONE -> result matches the reference model, out_data is stable, and a start pulse during DONE is ignored.
REQ-040 rst_n pulsed low after beat 50, then a new operation with data=1, wgt=1, bias=0 -> out_data=800.
REQ-041 Override N_TAPS=10, LANES=4, data=1, wgt=1, bias=0, with 3 beats and junk data in lanes 2-3 of beat 3 -> out_data=10.
